// File: rtl/alu_share_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Latency: accept at edge T, ALU driven T..T+1, result captured at T+1 and held until consumed.
// Backpressure: one operation in flight; both request readies low until the response is consumed.
module alu_share_arbiter #(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [3:0]          req0_op,
  input  logic [bit_size-1:0] req0_src1,
  input  logic [bit_size-1:0] req0_src2,
  input  logic [4:0]          req0_shamt,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [3:0]          req1_op,
  input  logic [bit_size-1:0] req1_src1,
  input  logic [bit_size-1:0] req1_src2,
  input  logic [4:0]          req1_shamt,

  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [bit_size-1:0] rsp0_result,
  output logic                rsp0_zero,

  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [bit_size-1:0] rsp1_result,
  output logic                rsp1_zero,

  output logic [3:0]          alu_op,
  output logic [bit_size-1:0] alu_src1,
  output logic [bit_size-1:0] alu_src2,
  output logic [4:0]          alu_shamt,
  input  logic [bit_size-1:0] alu_result,
  input  logic                alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Requester that won most recently; the other one wins the next tie.
  logic                r_last_grant;
  // Requester whose operation is currently in flight.
  logic                r_owner;

  logic [3:0]          r_alu_op;
  logic [bit_size-1:0] r_alu_src1;
  logic [bit_size-1:0] r_alu_src2;
  logic [4:0]          r_alu_shamt;

  // Single response register pair, shared by both response ports.
  logic [bit_size-1:0] r_rsp_result;
  logic                r_rsp_zero;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_accept;
  logic                w_consume;

  // Arbitration, consume detection and next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A lone requester always wins; on a tie the one not granted last time wins.
        w_grant0 = req0_valid & (~req1_valid | r_last_grant);
        w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
        if (w_grant0 | w_grant1) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // The ALU has had the whole cycle to settle on the registered operands.
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's ready can release the response; the other port is ignored.
        w_consume = r_owner ? rsp1_ready : rsp0_ready;
        if (w_consume) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grants are only raised on valid requesters, so any grant is an accept.
  assign w_accept = w_grant0 | w_grant1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ownership and round-robin history, updated only when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
      r_owner      <= w_grant1;
    end
  end

  // Winner's payload is sampled on the accept edge and held afterwards; it is
  // deliberately not cleared when the operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_op    <= 4'd0;
      r_alu_src1  <= '0;
      r_alu_src2  <= '0;
      r_alu_shamt <= 5'd0;
    end else if (w_grant0) begin
      r_alu_op    <= req0_op;
      r_alu_src1  <= req0_src1;
      r_alu_src2  <= req0_src2;
      r_alu_shamt <= req0_shamt;
    end else if (w_grant1) begin
      r_alu_op    <= req1_op;
      r_alu_src1  <= req1_src1;
      r_alu_src2  <= req1_src2;
      r_alu_shamt <= req1_shamt;
    end
  end

  // Capture the settled ALU outputs at the end of the execute cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_result <= alu_result;
      r_rsp_zero   <= alu_zero;
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;

  assign rsp0_valid  = (r_state == ST_RESP) & ~r_owner;
  assign rsp1_valid  = (r_state == ST_RESP) &  r_owner;
  assign rsp0_result = r_rsp_result;
  assign rsp1_result = r_rsp_result;
  assign rsp0_zero   = r_rsp_zero;
  assign rsp1_zero   = r_rsp_zero;

  assign alu_op      = r_alu_op;
  assign alu_src1    = r_alu_src1;
  assign alu_src2    = r_alu_src2;
  assign alu_shamt   = r_alu_shamt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, cycle reference model and response scoreboard.
module tb_alu_share_arbiter;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  sh;
  } op_t;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_src1, alu_src2;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  int   rdy_mode = 0;  // 0: held high, 1: random, 2: held low

  // Reference model state
  int   m_phase = 0;   // 0 idle, 1 execute, 2 response
  logic m_last  = 1'b1;
  logic m_owner = 1'b0;
  logic m_chk_rst = 1'b0;
  op_t  m_pay;

  alu_share_arbiter #(.bit_size(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behaviour of the shared ALU as described by its operation codes.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return b << sh;
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return ~(a | b);
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: return b >> sh;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_ref(alu_op, alu_src1, alu_src2, alu_shamt);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Cycle-level reference: expected readies, valids and ALU port drive.
  always @(negedge clk) begin
    logic e0, e1;
    if (m_chk_rst && !rst) begin
      chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
      chk("rst_alu_src1", alu_src1, 32'd0);
      chk("rst_alu_src2", alu_src2, 32'd0);
      chk("rst_alu_shamt", {27'd0, alu_shamt}, 32'd0);
      chk("rst_rsp_result", rsp0_result, 32'd0);
      chk("rst_rsp_zero", {31'd0, rsp0_zero}, 32'd0);
    end
    e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last == 1'b1);
    e1 = (m_phase == 0) && req1_valid && (!req0_valid || m_last == 1'b0);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, (m_phase == 2 && m_owner == 1'b0)});
    chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, (m_phase == 2 && m_owner == 1'b1)});
    if (m_phase == 1) begin
      chk("exec_alu_op", {28'd0, alu_op}, {28'd0, m_pay.op});
      chk("exec_alu_src1", alu_src1, m_pay.s1);
      chk("exec_alu_src2", alu_src2, m_pay.s2);
      chk("exec_alu_shamt", {27'd0, alu_shamt}, {27'd0, m_pay.sh});
    end
    if (rst) begin
      m_phase   = 0;
      m_last    = 1'b1;
      m_owner   = 1'b0;
      m_chk_rst = 1'b1;
      sb.delete();
    end else begin
      m_chk_rst = 1'b0;
      case (m_phase)
        0: if (e0 || e1) begin
             exp_t x;
             m_owner = e1;
             m_last  = e1;
             if (e1) m_pay = '{req1_op, req1_src1, req1_src2, req1_shamt};
             else    m_pay = '{req0_op, req0_src1, req0_src2, req0_shamt};
             x.port = e1;
             x.res  = alu_ref(m_pay.op, m_pay.s1, m_pay.s2, m_pay.sh);
             x.zero = (x.res == 32'd0);
             sb.push_back(x);
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
      endcase
    end
  end

  // Response monitor: compares presented responses against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (rsp0_valid || rsp1_valid)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected at %0t: got valid0=%0b valid1=%0b expected none", $time, rsp0_valid, rsp1_valid);
      end else begin
        exp_t e;
        e = sb[0];
        chk("rsp_port", {31'd0, rsp1_valid}, {31'd0, e.port});
        chk("rsp_result", e.port ? rsp1_result : rsp0_result, e.res);
        chk("rsp_zero", {31'd0, e.port ? rsp1_zero : rsp0_zero}, {31'd0, e.zero});
        chk("rsp_shared_result", rsp0_result, rsp1_result);
        if (e.port ? rsp1_ready : rsp0_ready) sb.delete(0);
      end
    end
  end

  function automatic op_t mk(input int op, input logic [31:0] a, input logic [31:0] b, input int sh);
    op_t o;
    o.op = 4'(op);
    o.s1 = a;
    o.s2 = b;
    o.sh = 5'(sh);
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    o.s1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom();
    o.s2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom();
    o.sh = 5'($urandom_range(0, 31));
    return o;
  endfunction

  // One clock: observe handshakes, then drive the next cycle's inputs.
  task automatic step();
    logic a0, a1;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
    if (a0 && q0.size() > 0) q0.delete(0);
    if (a1 && q1.size() > 0) q1.delete(0);
    if (q0.size() > 0) begin
      req0_valid = 1'b1; req0_op = q0[0].op; req0_src1 = q0[0].s1;
      req0_src2 = q0[0].s2; req0_shamt = q0[0].sh;
    end else begin
      req0_valid = 1'b0;
    end
    if (q1.size() > 0) begin
      req1_valid = 1'b1; req1_op = q1[0].op; req1_src1 = q1[0].s1;
      req1_src2 = q1[0].s2; req1_shamt = q1[0].sh;
    end else begin
      req1_valid = 1'b0;
    end
    rsp0_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    rsp1_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && m_phase == 0 && !req0_valid && !req1_valid) return;
      step();
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got q0=%0d q1=%0d phase=%0d expected all idle", q0.size(), q1.size(), m_phase);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    step();

    // Lone requester 0: add 5+7
    q0.push_back(mk(1, 32'd5, 32'd7, 0));
    drain();

    // Tie straight after reset: requester 0 first
    do_reset();
    q0.push_back(mk(2, 32'd9, 32'd9, 0));
    q1.push_back(mk(4, 32'd3, 32'd4, 0));
    drain();

    // Continuous contention with responses always consumed: alternating grants
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    drain();

    // Stalled response on port 1 while requester 0 waits
    rdy_mode = 2;
    q1.push_back(mk(0, 32'd0, 32'd1, 4));
    step();
    q0.push_back(mk(5, 32'hF0, 32'h0F, 0));
    for (int i = 0; i < 8; i++) step();
    rdy_mode = 0;
    drain();

    // Reset during the execute cycle
    q0.push_back(mk(1, 32'd100, 32'd23, 0));
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();

    // slt and an illegal opcode
    q0.push_back(mk(7, 32'd2, 32'd8, 0));
    q1.push_back(mk(12, 32'd55, 32'd66, 3));
    drain();

    // Randomised traffic with random response backpressure
    rdy_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
      step();
    end
    drain();
    rdy_mode = 0;
    step();
    step();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no completion expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
